// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: register map, bit
// positions, FSM encoding and the frame-to-FIFO-entry conversion.
package uart_rx_ctrl_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_DATA   = 4'h8;
    localparam logic [3:0] ADDR_LEVEL  = 4'hC;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_PAR_ODD = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int STAT_NE   = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_PERR = 3;
    localparam int STAT_FERR = 4;

    localparam int FRM_START    = 0;
    localparam int FRM_DATA_LSB = 1;
    localparam int FRM_DATA_MSB = 8;
    localparam int FRM_PARITY   = 9;
    localparam int FRM_STOP     = 10;
    localparam int FRAME_W      = 11;

    localparam int ENTRY_PERR = 8;
    localparam int ENTRY_FERR = 9;
    localparam int ENTRY_W    = 10;
    localparam int LEVEL_W    = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } rxState_e;

    // Parity is checked over data plus parity bit; the result must equal PAR_ODD.
    function automatic logic [ENTRY_W-1:0] frameToEntry(input logic [FRAME_W-1:0] frame,
                                                        input logic parOdd);
        logic perr;
        logic ferr;
        perr = (^frame[FRM_PARITY:FRM_DATA_LSB]) != parOdd;
        ferr = ~frame[FRM_STOP] | frame[FRM_START];
        return {ferr, perr, frame[FRM_DATA_MSB:FRM_DATA_LSB]};
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Receive FIFO: power-of-two depth, pointers wrap naturally, pop of an
// empty FIFO is ignored, push while full succeeds only alongside a pop.
module rx_fifo
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wrPtr;
    logic [AW-1:0]      rdPtr;
    logic               doPush;
    logic               doPop;

    assign empty  = (count == '0);
    assign full   = (count == LEVEL_W'(DEPTH));
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign dout   = mem[rdPtr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            count <= count + LEVEL_W'(doPush) - LEVEL_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: APB register block, receiver handshake FSM and
// a receive FIFO with sticky overflow/parity/framing status.
//
//  state   | meaning
//  IDLE    | receiver disabled or frame finished, rx_start low
//  ARM     | rx_start raised, one settling cycle
//  WAIT    | waiting for a rising edge of rx_store
//  CAPTURE | single cycle in which the latched frame is pushed
//  DONE    | rx_start low until rx_store drops or rx_clr_start
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [3:0]         paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    output logic               rx_start,
    input  logic               rx_store,
    input  logic               rx_clr_start,
    input  logic [FRAME_W-1:0] rx_data,
    output logic               irq
);

    rxState_e           state;
    rxState_e           stateNext;
    logic [2:0]         ctrlReg;
    logic               ovrFlag;
    logic               perrFlag;
    logic               ferrFlag;
    logic               rxStoreQ;
    logic [FRAME_W-1:0] frameQ;

    logic               access;
    logic               apbErr;
    logic               ctrlWr;
    logic               statusWr;
    logic               dataRd;
    logic               enKeep;
    logic               push;
    logic               dropped;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] fifoDout;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [LEVEL_W-1:0] fifoCount;
    logic [31:0]        rdData;
    logic               unusedPwdata;

    assign pready       = 1'b1;
    assign unusedPwdata = ^pwdata[31:5];

    assign access   = psel & penable;
    assign apbErr   = access & ((paddr[1:0] != 2'b00) |
                      (pwrite & ((paddr == ADDR_DATA) | (paddr == ADDR_LEVEL))));
    assign ctrlWr   = access & pwrite & (paddr == ADDR_CTRL);
    assign statusWr = access & pwrite & (paddr == ADDR_STATUS);
    assign dataRd   = access & ~pwrite & (paddr == ADDR_DATA);

    // A CTRL write that clears EN takes effect on the FSM in the same cycle.
    assign enKeep  = ctrlWr ? pwdata[CTRL_EN] : ctrlReg[CTRL_EN];
    assign push    = (state == CAPTURE) & enKeep;
    assign dropped = push & fifoFull & ~dataRd;
    assign entry   = frameToEntry(frameQ, ctrlReg[CTRL_PAR_ODD]);

    rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (dataRd),
        .din   (entry),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rxStoreQ <= 1'b0;
            frameQ   <= '0;
        end else begin
            state    <= stateNext;
            rxStoreQ <= rx_store;
            if (state == WAIT && rx_store && !rxStoreQ) frameQ <= rx_data;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (enKeep) stateNext = ARM;
            ARM:     stateNext = WAIT;
            WAIT:    if (rx_store && !rxStoreQ) stateNext = CAPTURE;
            CAPTURE: stateNext = DONE;
            DONE:    if (rx_clr_start || !rx_store) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (!enKeep) stateNext = IDLE;
    end

    assign rx_start = (state == ARM) | (state == WAIT) | (state == CAPTURE);

    // Status set events take priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrlReg  <= '0;
            ovrFlag  <= 1'b0;
            perrFlag <= 1'b0;
            ferrFlag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ctrlWr) ctrlReg <= pwdata[2:0];

            if (dropped)                            ovrFlag <= 1'b1;
            else if (statusWr && pwdata[STAT_OVR])  ovrFlag <= 1'b0;

            if (push && entry[ENTRY_PERR])          perrFlag <= 1'b1;
            else if (statusWr && pwdata[STAT_PERR]) perrFlag <= 1'b0;

            if (push && entry[ENTRY_FERR])          ferrFlag <= 1'b1;
            else if (statusWr && pwdata[STAT_FERR]) ferrFlag <= 1'b0;

            irq <= ctrlReg[CTRL_IRQ_EN] & (~fifoEmpty | ovrFlag | perrFlag | ferrFlag);
        end
    end

    always_comb begin
        rdData = '0;
        if (access && !pwrite && rst) begin
            case (paddr)
                ADDR_CTRL:   rdData[2:0] = ctrlReg;
                ADDR_STATUS: rdData[4:0] = {ferrFlag, perrFlag, ovrFlag, fifoFull, ~fifoEmpty};
                ADDR_DATA:   if (!fifoEmpty) rdData[ENTRY_W-1:0] = fifoDout;
                ADDR_LEVEL:  rdData[LEVEL_W-1:0] = fifoCount;
                default:     rdData = '0;
            endcase
        end
    end

    assign prdata  = rdData;
    assign pslverr = apbErr & rst;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized self-checking bench for uart_rx_ctrl against a queue-based
// model of the FIFO and sticky status flags.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  paddr = 4'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        rx_start;
    logic        rx_store = 1'b0;
    logic        rx_clr_start = 1'b0;
    logic [10:0] rx_data = 11'h0;
    logic        irq;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .rx_start     (rx_start),
        .rx_store     (rx_store),
        .rx_clr_start (rx_clr_start),
        .rx_data      (rx_data),
        .irq          (irq)
    );

    int nCompared = 0;
    int nMismatched = 0;

    logic [9:0] modelQ[$];
    logic mOvr = 0, mPerr = 0, mFerr = 0, mParOdd = 0, mIrqEn = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expStatus();
        logic [31:0] s;
        s = 32'h0;
        s[0] = modelQ.size() > 0;
        s[1] = modelQ.size() == DEPTH;
        s[2] = mOvr;
        s[3] = mPerr;
        s[4] = mFerr;
        return s;
    endfunction

    task automatic modelReset();
        modelQ.delete();
        mOvr = 0; mPerr = 0; mFerr = 0; mParOdd = 0; mIrqEn = 0;
    endtask

    // A captured frame: errors are judged from the frame, then it is queued or dropped.
    task automatic modelFrame(input logic [7:0] b, input logic par, input logic startB, input logic stopB);
        int ones;
        logic pe;
        logic fe;
        ones = $countones({par, b});
        pe = (ones % 2) != int'(mParOdd);
        fe = (stopB == 1'b0) || (startB == 1'b1);
        if (pe) mPerr = 1;
        if (fe) mFerr = 1;
        if (modelQ.size() == DEPTH) mOvr = 1;
        else modelQ.push_back({fe, pe, b});
    endtask

    task automatic apbRead(input logic [3:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(negedge clk);
        penable = 1;
        #1;
        d = prdata;
        e = pslverr;
        @(negedge clk);
        psel = 0; penable = 0;
    endtask

    task automatic apbWrite(input logic [3:0] a, input logic [31:0] v, output logic e);
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = v;
        @(negedge clk);
        penable = 1;
        #1;
        e = pslverr;
        @(negedge clk);
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic setCtrl(input logic en, input logic po, input logic ie);
        logic e;
        apbWrite(4'h0, {29'h0, ie, po, en}, e);
        checkVal("ctrlWrErr", 32'(e), 0);
        mParOdd = po;
        mIrqEn = ie;
    endtask

    task automatic checkRead(input string tag);
        logic [31:0] d;
        logic e;
        logic [31:0] exp;
        exp = 0;
        if (modelQ.size() > 0) exp = 32'(modelQ.pop_front());
        apbRead(4'h8, d, e);
        checkVal(tag, d, exp);
        checkVal({tag, "Err"}, 32'(e), 0);
    endtask

    task automatic checkRegs(input string tag);
        logic [31:0] d;
        logic e;
        logic expIrq;
        apbRead(4'h4, d, e);
        checkVal({tag, "Status"}, d, expStatus());
        apbRead(4'hC, d, e);
        checkVal({tag, "Level"}, d, modelQ.size());
        expIrq = mIrqEn & ((modelQ.size() > 0) | mOvr | mPerr | mFerr);
        checkVal({tag, "Irq"}, 32'(irq), 32'(expIrq));
    endtask

    // Leaves the bench on a negedge with the receiver sitting in WAIT.
    task automatic waitArmed();
        int n;
        n = 0;
        @(negedge clk);
        while (rx_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkVal("armed", 32'(rx_start), 1);
        @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic par, input logic startB,
                             input logic stopB, input int hold);
        waitArmed();
        rx_data = {stopB, par, b, startB};
        rx_store = 1;
        repeat (hold) @(negedge clk);
        rx_store = 0;
        repeat (2) @(negedge clk);
        modelFrame(b, par, startB, stopB);
    endtask

    task automatic goodFrame(input logic [7:0] b, input int hold);
        sendFrame(b, (^b) ^ mParOdd, 1'b0, 1'b1, hold);
    endtask

    task automatic randFrame();
        logic [7:0] b;
        logic par;
        b = 8'($urandom_range(0, 255));
        par = (^b) ^ mParOdd ^ ($urandom_range(0, 3) == 0);
        sendFrame(b, par, $urandom_range(0, 5) == 0, $urandom_range(0, 5) != 0,
                  int'($urandom_range(1, 5)));
    endtask

    // DATA read whose access phase coincides with the CAPTURE cycle.
    task automatic frameWithRead(input string tag, input logic [7:0] b);
        logic [31:0] d;
        logic e;
        logic [31:0] exp;
        waitArmed();
        rx_data = {1'b1, (^b) ^ mParOdd, b, 1'b0};
        rx_store = 1;
        psel = 1; penable = 0; pwrite = 0; paddr = 4'h8;
        @(negedge clk);
        penable = 1;
        #1;
        d = prdata;
        e = pslverr;
        @(negedge clk);
        psel = 0; penable = 0; rx_store = 0;
        repeat (2) @(negedge clk);
        exp = 0;
        if (modelQ.size() > 0) exp = 32'(modelQ.pop_front());
        modelFrame(b, (^b) ^ mParOdd, 1'b0, 1'b1);
        checkVal(tag, d, exp);
        checkVal({tag, "Err"}, 32'(e), 0);
    endtask

    initial begin
        logic [31:0] d;
        logic e;
        int n;

        // Reset: outputs low even with an illegal access pending
        psel = 1; penable = 1; paddr = 4'h1;
        repeat (3) @(negedge clk);
        #1;
        checkVal("rstPrdata", prdata, 0);
        checkVal("rstPslverr", 32'(pslverr), 0);
        checkVal("rstStart", 32'(rx_start), 0);
        checkVal("rstIrq", 32'(irq), 0);
        psel = 0; penable = 0; paddr = 0;
        @(negedge clk);
        rst = 1;
        modelReset();
        apbRead(4'h0, d, e);
        checkVal("rstCtrl", d, 0);
        checkRegs("rst");
        checkVal("pready", 32'(pready), 1);

        // Register map: unused bits, bad offsets, RO writes
        apbWrite(4'h0, 32'hFFFF_FFF8, e);
        apbRead(4'h0, d, e);
        checkVal("ctrlUnused", d, 0);
        apbRead(4'h2, d, e);
        checkVal("badRdData", d, 0);
        checkVal("badRdErr", 32'(e), 1);
        apbWrite(4'h8, 32'h1, e);
        checkVal("wrDataErr", 32'(e), 1);
        apbWrite(4'hC, 32'h1, e);
        checkVal("wrLevelErr", 32'(e), 1);
        apbWrite(4'h6, 32'h7, e);
        checkVal("badWrErr", 32'(e), 1);
        apbRead(4'h0, d, e);
        checkVal("badWrNoEffect", d, 0);
        checkRead("emptyRead");

        // Basic frame 0xA5, even parity
        setCtrl(1, 0, 0);
        goodFrame(8'hA5, 1);
        checkRegs("a5");
        checkRead("a5Data");
        checkRegs("a5After");

        // Held rx_store gives one push; clear-start re-arms promptly
        waitArmed();
        rx_data = {1'b1, 1'b0, 8'h3C, 1'b0};
        rx_store = 1;
        repeat (2) @(negedge clk);
        checkVal("doneStart", 32'(rx_start), 0);
        rx_clr_start = 1;
        @(negedge clk);
        rx_clr_start = 0;
        checkVal("clrStart", 32'(rx_start), 0);
        n = 0;
        while (rx_start !== 1'b1 && n < 3) begin
            @(negedge clk);
            n++;
        end
        checkVal("rearmWithin2", 32'(n >= 1 && n <= 2), 1);
        @(negedge clk);
        rx_store = 0;
        repeat (2) @(negedge clk);
        modelFrame(8'h3C, 1'b0, 1'b0, 1'b1);
        checkRegs("hold");
        checkRead("holdData");

        // Parity error on 0x01 with parity bit 0, then W1C
        sendFrame(8'h01, 1'b0, 1'b0, 1'b1, 2);
        checkRegs("perr");
        apbWrite(4'h4, 32'h08, e);
        mPerr = 0;
        checkRegs("perrClr");
        checkRead("perrData");

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int act;
            act = int'($urandom_range(0, 9));
            if (act < 3) checkRead("rndData");
            else if (act == 3) begin
                logic [31:0] m;
                m = 32'($urandom_range(0, 31));
                apbWrite(4'h4, m, e);
                checkVal("rndW1cErr", 32'(e), 0);
                if (m[2]) mOvr = 0;
                if (m[3]) mPerr = 0;
                if (m[4]) mFerr = 0;
            end else if (act == 4)
                setCtrl(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            randFrame();
            if (i % 10 == 9) checkRegs("rnd");
        end
        while (modelQ.size() > 0) checkRead("drain");
        checkRead("drainEmpty");

        // Overflow: five frames into four entries
        setCtrl(1, 0, 1);
        apbWrite(4'h4, 32'h1C, e);
        mOvr = 0; mPerr = 0; mFerr = 0;
        for (int i = 0; i < 5; i++) goodFrame(8'(8'h10 + i), 1);
        checkRegs("ovr");
        for (int i = 0; i < 4; i++) checkRead("ovrData");

        // Full FIFO with a pop in the capture cycle: no overflow
        apbWrite(4'h4, 32'h1C, e);
        mOvr = 0;
        for (int i = 0; i < 4; i++) goodFrame(8'(8'h40 + i), 1);
        frameWithRead("fullPopPush", 8'h55);
        checkRegs("fullPopPush");
        while (modelQ.size() > 0) checkRead("drain2");

        // Empty FIFO with a pop in the capture cycle: read 0, push lands
        frameWithRead("emptyPopPush", 8'h66);
        checkRegs("emptyPopPush");

        // Clear EN while waiting: receiver disarms, frame ignored
        waitArmed();
        setCtrl(0, mParOdd, mIrqEn);
        checkVal("enClrStart", 32'(rx_start), 0);
        rx_data = {1'b1, 1'b0, 8'h77, 1'b0};
        rx_store = 1;
        repeat (2) @(negedge clk);
        rx_store = 0;
        repeat (3) @(negedge clk);
        checkVal("enClrIdle", 32'(rx_start), 0);
        checkRegs("enClr");

        // Reset in the middle of a frame
        setCtrl(1, mParOdd, 1);
        waitArmed();
        rx_data = {1'b1, 1'b0, 8'h99, 1'b0};
        rx_store = 1;
        @(negedge clk);
        rst = 0;
        psel = 1; penable = 1; paddr = 4'h1;
        #1;
        checkVal("midRstStart", 32'(rx_start), 0);
        checkVal("midRstIrq", 32'(irq), 0);
        checkVal("midRstPrdata", prdata, 0);
        checkVal("midRstPslverr", 32'(pslverr), 0);
        repeat (2) @(negedge clk);
        psel = 0; penable = 0; paddr = 0; rx_store = 0;
        @(negedge clk);
        rst = 1;
        modelReset();
        apbRead(4'h0, d, e);
        checkVal("midRstCtrl", d, 0);
        checkRegs("midRst");
        repeat (3) @(negedge clk);
        checkVal("midRstIdle", 32'(rx_start), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, receive FIFO entries (power of 2, range 2..16).
REQ-002 clk  in  1  system clock; all logic is posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 psel, penable, pwrite  in  1 each  APB control.
REQ-005 paddr  in  4  byte address; valid offsets 0x0, 0x4, 0x8, 0xC.
REQ-006 pwdata  in  32  APB write data.
REQ-007 prdata  out  32  APB read data.
REQ-008 pready  out  1  tied 1 (no wait states).
REQ-009 pslverr  out  1  error response.
REQ-010 rx_start  out  1  arms the receiver.
REQ-011 rx_store  in  1  receiver frame complete; may be held for more than 1 cycle.
REQ-012 rx_clr_start  in  1  receiver requests rx_start deassert.
REQ-013 rx_data  in  11  frame: [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
REQ-014 irq  out  1  level interrupt.

Function
REQ-015 Registers:
- 0x0 CTRL, RW: [0] EN, [1] PAR_ODD, [2] IRQ_EN.
- 0x4 STATUS: [0] NE, RO; [1] FULL, RO; [2] OVR, W1C; [3] PERR, W1C; [4] FERR, W1C.
- 0x8 DATA, RO: [7:0] byte, [8] perr, [9] ferr.
- 0xC LEVEL, RO: [4:0] FIFO count.
- Unused bits read 0.
REQ-016 An APB access completes in the cycle psel&penable=1; that cycle is the access phase.
REQ-017 pslverr=1 in the access phase for an invalid offset or a write to 0x8/0xC; such writes have no effect.
REQ-018 A DATA read pops exactly one entry in the access phase; the same-cycle prdata is the popped entry.
REQ-019 A DATA read on an empty FIFO returns 0, does not pop, and gives pslverr=0.
REQ-020 FSM states IDLE, ARM, WAIT, CAPTURE, DONE:
- IDLE->ARM when EN=1.
- ARM->WAIT unconditionally.
- WAIT->CAPTURE on the rising edge of rx_store.
- CAPTURE->DONE.
- DONE->IDLE on rx_clr_start, or when rx_store=0.
REQ-021 rx_start=1 in ARM, WAIT and CAPTURE; rx_start=0 in IDLE and DONE.
REQ-022 CAPTURE lasts exactly 1 cycle and pushes at most one entry per frame.
REQ-023 Error flags:
- Parity error: XOR(rx_data[9:1]) != PAR_ODD.
- Frame error: rx_data[10]=0, or rx_data[0]=1.
- Each error sets its entry bit and the sticky PERR/FERR.
REQ-024 Push when full with no same-cycle pop: the frame is dropped and OVR is set; FIFO contents are unchanged.
REQ-025 Simultaneous push and pop when full: both occur; LEVEL stays DEPTH; OVR is not set.
REQ-026 Simultaneous push and pop when empty: the pop returns 0 (per REQ-019); the push succeeds and LEVEL becomes 1.
REQ-027 W1C behaviour: writing 1 clears the flag. If a set event occurs in the same cycle, set wins.
REQ-028 Clearing EN in any state forces IDLE next cycle with rx_start=0; the in-flight frame is discarded; FIFO and status are retained.
REQ-029 irq = IRQ_EN & (NE | OVR | PERR | FERR), registered, with 1-cycle latency.
REQ-030 FIFO read/write pointers wrap modulo DEPTH.

Reset
REQ-031 While rst=0 and on its release, all of the following are 0:
- CTRL, STATUS flags, FIFO pointers and count.
- prdata, pslverr, rx_start, irq.
- FSM state = IDLE.
REQ-032 Reset asserted mid-frame or mid-APB access aborts the operation immediately; no partial push occurs.

Structure
REQ-033 A shared package holds register offsets, CTRL/STATUS bit indices, FSM state encoding and frame field positions.
REQ-034 The FIFO is a sub-module named rx_fifo with push, pop, din[9:0], dout, full, empty and count ports.

Verification
REQ-035 EN=1, parity even, frame 0x0 byte 0xA5 with correct parity, stop=1: one rx_store pulse -> LEVEL=1, NE=1; DATA read = 0x0A5; LEVEL=0.
REQ-036 rx_store held 5 cycles -> exactly one push; rx_clr_start -> rx_start=0, then re-armed within 2 cycles.
REQ-037 Byte 0x01 with parity bit 0, PAR_ODD=0 -> DATA = 0x101, PERR=1; write STATUS 0x08 -> PERR=0.
REQ-038 Push 5 frames with DEPTH=4 and no reads -> LEVEL=4, FULL=1, OVR=1; reads return the first 4 bytes in order.
REQ-039 FIFO full, DATA read in the CAPTURE cycle -> LEVEL stays 4, OVR=0.
REQ-040 Two cases:
- Clear EN while in WAIT -> rx_start=0 next cycle, no push.
- Assert rst mid-frame -> all outputs 0 and FSM = IDLE.
